// File: rtl/fcmp_stage.sv
// Two-stage RISC-V style float compare (feq/flt/fle); NaN handling under `ifdef FCMP_NAN_EN.
// Latency 2 cycles, throughput 1/cycle; valid/ready backpressure stalls S1 behind a held S2.
module fcmp_stage #(
  parameter int TAG_W = 6
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [31:0]      in_x1,
  input  logic [31:0]      in_x2,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_nv,
  output logic [1:0]       occupancy
);

  localparam logic [1:0] OP_FEQ = 2'b00;
  localparam logic [1:0] OP_FLT = 2'b01;
  localparam logic [1:0] OP_FLE = 2'b10;

  logic             s1_vld_q, s1_vld_d;
  logic [1:0]       s1_op_q;
  logic [31:0]      s1_x1_q, s1_x2_q;
  logic [TAG_W-1:0] s1_tag_q;

  logic             s2_vld_q, s2_vld_d;
  logic [31:0]      s2_data_q;
  logic [TAG_W-1:0] s2_tag_q;
  logic             s2_nv_q;

  logic s1_adv, accept, consume;
  logic res_bit, res_nv;
  logic lt, eq, both_zero;
  logic [30:0] mag1, mag2;
  logic sgn1, sgn2;

  // Flush dominates every handshake: nothing moves and nothing is accepted.
  assign s1_adv   = s1_vld_q & (~s2_vld_q | out_ready) & ~flush;
  assign in_ready = ~flush & (~s1_vld_q | s1_adv);
  assign accept   = in_valid & in_ready;
  assign consume  = s2_vld_q & out_ready;

  assign mag1      = s1_x1_q[30:0];
  assign mag2      = s1_x2_q[30:0];
  assign sgn1      = s1_x1_q[31];
  assign sgn2      = s1_x2_q[31];
  assign both_zero = (mag1 == 31'd0) & (mag2 == 31'd0);
  assign eq        = (s1_x1_q == s1_x2_q) | both_zero;
  assign lt        = (~sgn1 & ~sgn2 & (mag1 < mag2))
                   | ( sgn1 & ~sgn2 & ~both_zero)
                   | ( sgn1 &  sgn2 & (mag1 > mag2));

`ifdef FCMP_NAN_EN
  logic nan1, nan2, snan1, snan2, any_nan, any_snan;
  assign nan1     = (&s1_x1_q[30:23]) & (|s1_x1_q[22:0]);
  assign nan2     = (&s1_x2_q[30:23]) & (|s1_x2_q[22:0]);
  assign snan1    = nan1 & ~s1_x1_q[22];
  assign snan2    = nan2 & ~s1_x2_q[22];
  assign any_nan  = nan1 | nan2;
  assign any_snan = snan1 | snan2;

  always_comb begin
    res_bit = 1'b0;
    res_nv  = 1'b0;
    case (s1_op_q)
      OP_FEQ: begin
        res_bit = eq & ~any_nan;
        res_nv  = any_snan;
      end
      OP_FLT: begin
        res_bit = lt & ~any_nan;
        res_nv  = any_nan;
      end
      OP_FLE: begin
        res_bit = (lt | eq) & ~any_nan;
        res_nv  = any_nan;
      end
      default: begin
        res_bit = 1'b0;
        res_nv  = 1'b0;
      end
    endcase
  end
`else
  always_comb begin
    res_bit = 1'b0;
    res_nv  = 1'b0;
    case (s1_op_q)
      OP_FEQ:  res_bit = eq;
      OP_FLT:  res_bit = lt;
      OP_FLE:  res_bit = lt | eq;
      default: res_bit = 1'b0;
    endcase
  end
`endif

  always_comb begin
    s1_vld_d = s1_vld_q;
    s2_vld_d = s2_vld_q;
    if (flush) begin
      s1_vld_d = 1'b0;
      s2_vld_d = 1'b0;
    end else begin
      if (accept)      s1_vld_d = 1'b1;
      else if (s1_adv) s1_vld_d = 1'b0;
      if (s1_adv)       s2_vld_d = 1'b1;
      else if (consume) s2_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_vld_q <= 1'b0;
      s1_op_q  <= 2'b00;
      s1_x1_q  <= 32'd0;
      s1_x2_q  <= 32'd0;
      s1_tag_q <= '0;
    end else begin
      s1_vld_q <= s1_vld_d;
      if (accept) begin
        s1_op_q  <= in_op;
        s1_x1_q  <= in_x1;
        s1_x2_q  <= in_x2;
        s1_tag_q <= in_tag;
      end
    end
  end

  // S2 payload only changes on advance, so it is stable while the result is stalled.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s2_vld_q  <= 1'b0;
      s2_data_q <= 32'd0;
      s2_tag_q  <= '0;
      s2_nv_q   <= 1'b0;
    end else begin
      s2_vld_q <= s2_vld_d;
      if (s1_adv) begin
        s2_data_q <= {31'd0, res_bit};
        s2_tag_q  <= s1_tag_q;
        s2_nv_q   <= res_nv;
      end
    end
  end

  assign out_valid = s2_vld_q;
  assign out_data  = s2_data_q;
  assign out_tag   = s2_tag_q;
  assign out_nv    = s2_nv_q;
  assign occupancy = {1'b0, s1_vld_q} + {1'b0, s2_vld_q};

endmodule

// File: tb/tb_fcmp_stage.sv
// Directed-vector bench for fcmp_stage: compare results, latency, stall, flush and reset.
module tb_fcmp_stage;
  localparam int TAG_W = 6;

  localparam logic [1:0] OP_FEQ = 2'b00;
  localparam logic [1:0] OP_FLT = 2'b01;
  localparam logic [1:0] OP_FLE = 2'b10;
  localparam logic [1:0] OP_RSV = 2'b11;

  localparam logic [31:0] ONE  = 32'h3F80_0000;
  localparam logic [31:0] TWO  = 32'h4000_0000;
  localparam logic [31:0] MONE = 32'hBF80_0000;
  localparam logic [31:0] MTWO = 32'hC000_0000;
  localparam logic [31:0] PZ   = 32'h0000_0000;
  localparam logic [31:0] NZ   = 32'h8000_0000;
  localparam logic [31:0] QNAN = 32'h7FC0_0000;
  localparam logic [31:0] SNAN = 32'h7F80_0001;

  logic             clk = 1'b0;
  logic             rstn, flush, in_valid, in_ready, out_valid, out_ready, out_nv;
  logic [1:0]       in_op, occupancy;
  logic [31:0]      in_x1, in_x2, out_data;
  logic [TAG_W-1:0] in_tag, out_tag;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fcmp_stage #(.TAG_W(TAG_W)) dut (
    .clk(clk), .rstn(rstn), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_x1(in_x1), .in_x2(in_x2), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_tag(out_tag), .out_nv(out_nv), .occupancy(occupancy)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [TAG_W-1:0] tag);
    in_op    = op;
    in_x1    = a;
    in_x2    = b;
    in_tag   = tag;
    in_valid = 1'b1;
  endtask

  // Single issue with out_ready high: result must appear exactly two edges after acceptance.
  task automatic issue_one(input string name, input logic [1:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [TAG_W-1:0] tag,
                           input logic exp_d, input logic exp_nv);
    drive(op, a, b, tag);
    #1;
    check({name, ".rdy"}, 32'(in_ready), 1);
    tick;
    in_valid = 1'b0;
    check({name, ".lat1"}, 32'(out_valid), 0);
    tick;
    check({name, ".vld"}, 32'(out_valid), 1);
    check({name, ".data"}, out_data, {31'd0, exp_d});
    check({name, ".tag"}, 32'(out_tag), 32'(tag));
    check({name, ".nv"}, 32'(out_nv), {31'd0, exp_nv});
    tick;
    check({name, ".drain"}, 32'(occupancy), 0);
  endtask

  logic [1:0]       bb_op  [3];
  logic [31:0]      bb_a   [3];
  logic [31:0]      bb_b   [3];
  logic [TAG_W-1:0] bb_tag [3];
  logic             bb_res [3];
  logic             seen;

  initial begin
    rstn = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_op = OP_FEQ; in_x1 = PZ; in_x2 = PZ; in_tag = '0;
    #1 rstn = 1'b0;
    #12;
    check("rst.occ", 32'(occupancy), 0);
    check("rst.vld", 32'(out_valid), 0);
    check("rst.data", out_data, 0);
    check("rst.tag", 32'(out_tag), 0);
    check("rst.nv", 32'(out_nv), 0);
    check("rst.rdy", 32'(in_ready), 1);
    @(negedge clk) rstn = 1'b1;
    tick;

    issue_one("flt_1_2",    OP_FLT, ONE,  TWO,  6'd5,  1'b1, 1'b0);
    issue_one("feq_nz_pz",  OP_FEQ, NZ,   PZ,   6'd6,  1'b1, 1'b0);
    issue_one("flt_nz_pz",  OP_FLT, NZ,   PZ,   6'd7,  1'b0, 1'b0);
    issue_one("fle_nz_pz",  OP_FLE, NZ,   PZ,   6'd8,  1'b1, 1'b0);
    issue_one("flt_m1_m2",  OP_FLT, MONE, MTWO, 6'd9,  1'b0, 1'b0);
    issue_one("flt_m2_m1",  OP_FLT, MTWO, MONE, 6'd10, 1'b1, 1'b0);
    issue_one("fle_2_1",    OP_FLE, TWO,  ONE,  6'd11, 1'b0, 1'b0);
    issue_one("flt_m1_1",   OP_FLT, MONE, ONE,  6'd12, 1'b1, 1'b0);
    issue_one("rsv_1_1",    OP_RSV, ONE,  ONE,  6'd13, 1'b0, 1'b0);
`ifdef FCMP_NAN_EN
    issue_one("fle_qnan",   OP_FLE, QNAN, ONE,  6'd14, 1'b0, 1'b1);
    issue_one("feq_qnan",   OP_FEQ, QNAN, ONE,  6'd15, 1'b0, 1'b0);
    issue_one("feq_snan",   OP_FEQ, SNAN, ONE,  6'd16, 1'b0, 1'b1);
    issue_one("feq_qq",     OP_FEQ, QNAN, QNAN, 6'd17, 1'b0, 1'b0);
`else
    issue_one("fle_qnan",   OP_FLE, QNAN, ONE,  6'd14, 1'b0, 1'b0);
    issue_one("feq_qnan",   OP_FEQ, QNAN, ONE,  6'd15, 1'b0, 1'b0);
    issue_one("feq_snan",   OP_FEQ, SNAN, ONE,  6'd16, 1'b0, 1'b0);
    issue_one("feq_qq",     OP_FEQ, QNAN, QNAN, 6'd17, 1'b1, 1'b0);
`endif

    // Back-to-back issues at full rate: entry i appears at iteration i+2.
    bb_op[0] = OP_FEQ; bb_a[0] = ONE;  bb_b[0] = ONE; bb_tag[0] = 6'd20; bb_res[0] = 1'b1;
    bb_op[1] = OP_FLT; bb_a[1] = TWO;  bb_b[1] = ONE; bb_tag[1] = 6'd21; bb_res[1] = 1'b0;
    bb_op[2] = OP_FLE; bb_a[2] = MONE; bb_b[2] = ONE; bb_tag[2] = 6'd22; bb_res[2] = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i >= 2) begin
        check("bb.vld", 32'(out_valid), 1);
        check("bb.tag", 32'(out_tag), 32'(bb_tag[i-2]));
        check("bb.data", out_data, {31'd0, bb_res[i-2]});
      end
      if (i < 3) begin
        drive(bb_op[i], bb_a[i], bb_b[i], bb_tag[i]);
        #1 check("bb.rdy", 32'(in_ready), 1);
      end else begin
        in_valid = 1'b0;
      end
      tick;
    end
    check("bb.empty", 32'(out_valid), 0);

    // Stall with out_ready low, then drain in order.
    out_ready = 1'b0;
    drive(OP_FEQ, ONE, ONE, 6'd1);
    tick;
    drive(OP_FLT, TWO, ONE, 6'd2);
    #1 check("st.rdy2", 32'(in_ready), 1);
    tick;
    drive(OP_FLE, ONE, TWO, 6'd3);
    #1;
    check("st.rdy3", 32'(in_ready), 0);
    check("st.occ", 32'(occupancy), 2);
    check("st.data", out_data, 1);
    check("st.tag", 32'(out_tag), 1);
    tick;
    check("st.rdy3b", 32'(in_ready), 0);
    check("st.hold_data", out_data, 1);
    check("st.hold_tag", 32'(out_tag), 1);
    check("st.occ2", 32'(occupancy), 2);
    out_ready = 1'b1;
    #1 check("st.rdy_rel", 32'(in_ready), 1);
    tick;
    in_valid = 1'b0;
    check("dr.tag2", 32'(out_tag), 2);
    check("dr.data2", out_data, 0);
    tick;
    check("dr.tag3", 32'(out_tag), 3);
    check("dr.data3", out_data, 1);
    check("dr.vld3", 32'(out_valid), 1);
    tick;
    check("dr.empty", 32'(out_valid), 0);
    check("dr.occ", 32'(occupancy), 0);

    // Flush with both stages full and an issue pending.
    out_ready = 1'b0;
    drive(OP_FEQ, ONE, ONE, 6'd30);
    tick;
    drive(OP_FEQ, TWO, TWO, 6'd31);
    tick;
    check("fl.occ_pre", 32'(occupancy), 2);
    drive(OP_FEQ, ONE, ONE, 6'd32);
    flush = 1'b1;
    out_ready = 1'b1;
    #1 check("fl.rdy", 32'(in_ready), 0);
    tick;
    flush = 1'b0;
    in_valid = 1'b0;
    check("fl.occ", 32'(occupancy), 0);
    check("fl.vld", 32'(out_valid), 0);
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (out_valid) seen = 1'b1;
      tick;
    end
    check("fl.ghost", 32'(seen), 0);
    issue_one("post_flush", OP_FLT, ONE, TWO, 6'd33, 1'b1, 1'b0);

    // Asynchronous reset mid-flight discards both entries.
    out_ready = 1'b0;
    drive(OP_FEQ, ONE, ONE, 6'd40);
    tick;
    drive(OP_FEQ, ONE, ONE, 6'd41);
    tick;
    in_valid = 1'b0;
    check("ar.occ_pre", 32'(occupancy), 2);
    rstn = 1'b0;
    #1;
    check("ar.occ", 32'(occupancy), 0);
    check("ar.vld", 32'(out_valid), 0);
    check("ar.data", out_data, 0);
    check("ar.rdy", 32'(in_ready), 1);
    @(negedge clk) rstn = 1'b1;
    out_ready = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick;
      if (out_valid) seen = 1'b1;
    end
    check("ar.ghost", 32'(seen), 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/fcmp_stage.md
FCMP_STAGE -- requirements
Module: fcmp_stage

Interface
REQ-001 SHALL have parameter TAG_W, default 6, giving the width of the destination-register tag carried alongside each compare.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-003 SHALL have port rstn  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port flush  input  1  synchronous pipeline kill.
REQ-005 SHALL have port in_valid  input  1  upstream has a compare to issue.
REQ-006 SHALL have port in_ready  output  1  stage accepts the issue this cycle.
REQ-007 SHALL have port in_op  input  2  operation: 00 feq, 01 flt, 10 fle, 11 reserved.
REQ-008 SHALL have port in_x1 / in_x2  input  32 each  IEEE-754 single operands.
REQ-009 SHALL have port in_tag  input  TAG_W  destination tag.
REQ-010 SHALL have port out_valid  output  1  result available.
REQ-011 SHALL have port out_ready  input  1  downstream (writeback) consumes the result.
REQ-012 SHALL have port out_data  output  32  result, 0x00000000 or 0x00000001.
REQ-013 SHALL have port out_tag  output  TAG_W  tag of the returned result.
REQ-014 SHALL have port out_nv  output  1  invalid-operation flag; tied 0 without FCMP_NAN_EN.
REQ-015 SHALL have port occupancy  output  2  number of valid entries in flight, 0..2.

Function
REQ-016 SHALL be a two-stage pipeline: S1 registers op/x1/x2/tag on an accepted transfer; S2 registers the computed result and tag.
REQ-017 SHALL accept an issue when in_valid & in_ready; in_ready = ~S1.valid | (S1 advances this cycle).
REQ-018 SHALL advance S1 into S2 when S1.valid & (~S2.valid | out_ready).
REQ-019 SHALL present out_valid = S2.valid; a result is consumed when out_valid & out_ready.
REQ-020 SHALL hold out_data/out_tag/out_nv stable while out_valid & ~out_ready.
REQ-021 SHALL give latency of exactly 2 cycles from acceptance to out_valid with out_ready held high, and throughput of 1 per cycle.
REQ-022 SHALL compute lt = (both signs 0 & |x1|<|x2|) | (s1=1 & s2=0 & not both magnitudes zero) | (both signs 1 & |x1|>|x2|), where magnitudes are bits [30:0] compared unsigned.
REQ-023 SHALL compute eq = (x1==x2) | (both bits [30:0] zero), so +0 equals -0.
REQ-024 SHALL return feq=eq, flt=lt, fle=lt|eq, and reserved op = 0, zero-extended into out_data.
REQ-025 SHALL, on flush, clear S1.valid and S2.valid at the next edge, drop any issue presented in the same cycle, and hold in_ready low for that cycle.
REQ-026 SHALL treat flush as having priority over simultaneous accept, advance and consume.
REQ-027 SHALL drive occupancy = S1.valid + S2.valid.

Reset
REQ-028 SHALL on rstn low immediately clear S1.valid, S2.valid, out_data, out_tag and out_nv to 0; after reset, occupancy = 0 and in_ready = 1.
REQ-029 SHALL discard entries in flight when reset is asserted mid-operation; no result for them is ever presented.

Configuration
REQ-030 SHALL, with FCMP_NAN_EN defined, detect NaN (exp=0xFF, frac!=0) on either operand: feq/flt/fle return 0; out_nv=1 for flt/fle with any NaN and for feq with a signalling NaN (frac[22]=0).
REQ-031 SHALL, without FCMP_NAN_EN, apply REQ-022..024 to raw bit patterns with no NaN special case and tie out_nv to 0.

Verification
REQ-032 SHALL cover: flt x1=0x3F800000 (1.0), x2=0x40000000 (2.0), out_ready=1 -> out_data=1 exactly 2 cycles after acceptance, tag echoed.
REQ-033 SHALL cover: feq x1=0x80000000, x2=0x00000000 -> 1; flt on the same operands -> 0; fle -> 1.
REQ-034 SHALL cover: flt x1=0xBF800000 (-1.0), x2=0xC0000000 (-2.0) -> 0; swapped operands -> 1.
REQ-035 SHALL cover: 3 back-to-back issues with out_ready=0 -> third issue stalled (in_ready=0), occupancy=2, out_data stable; releasing out_ready drains all 3 in order.
REQ-036 SHALL cover: flush asserted with occupancy=2 and in_valid=1 -> next cycle occupancy=0, out_valid=0, the flushed issue is never returned.
REQ-037 SHALL cover, with FCMP_NAN_EN: fle x1=0x7FC00000, x2=0x3F800000 -> out_data=0, out_nv=1; feq on the same operands -> out_data=0, out_nv=0.
